id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 232 +++++++++++++++++++++++
 tb/tb_id_stage.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage -- instruction decode stage of a 5-stage RV32I subset pipeline.
//
// Decodes the instruction held in the IF/ID register, reads operands from a
// 32 x 32 register file (with same-cycle writeback bypass), resolves BEQ/BNE/
// JAL in this stage and loads the ID/EX pipeline register every cycle.
// A taken branch squashes the instruction that follows it (one bubble).
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   if_id_pc_plus4      PC+4 of the instruction in IF/ID
//   if_id_instr         instruction in IF/ID
//   wb_reg_write        writeback enable
//   wb_rd, wb_data      writeback destination / data
//   branch_taken        redirect request to fetch (combinational)
//   branch_target       redirect address (combinational)
//   id_ex_*             registered operands, fields and controls for EX
//   illegal_instr       registered one-cycle pulse per illegal instruction
// -----------------------------------------------------------------------------
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_id_pc_plus4,
  input  logic [31:0] if_id_instr,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic [31:0] id_ex_pc_plus4,
  output logic [31:0] id_ex_rs1_data,
  output logic [31:0] id_ex_rs2_data,
  output logic [31:0] id_ex_imm,
  output logic [4:0]  id_ex_rd,
  output logic [2:0]  id_ex_funct3,
  output logic        id_ex_funct7b5,
  output logic        id_ex_alu_src,
  output logic        id_ex_mem_read,
  output logic        id_ex_mem_write,
  output logic        id_ex_reg_write,
  output logic        id_ex_mem_to_reg,
  output logic        id_ex_is_jal,
  output logic        illegal_instr
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // Instruction fields
  logic [6:0] w_opcode;
  logic [4:0] w_rd;
  logic [2:0] w_funct3;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;

  assign w_opcode = if_id_instr[6:0];
  assign w_rd     = if_id_instr[11:7];
  assign w_funct3 = if_id_instr[14:12];
  assign w_rs1    = if_id_instr[19:15];
  assign w_rs2    = if_id_instr[24:20];

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [31:0] r_regs [32];
  logic        w_wb_en;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;

  assign w_wb_en = wb_reg_write && (wb_rd != 5'd0);

  // NOTE: the register file has an architectural reset to zero, so it is built
  // from resettable flops rather than a RAM macro; entry 0 is never written.
  // NOTE: all state in clocked blocks uses non-blocking assignment so every
  // flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wb_en) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // Reads see a same-cycle writeback, so WB -> ID needs no extra bubble.
  assign w_rs1_data = (w_rs1 == 5'd0)                  ? 32'd0   :
                      (w_wb_en && (wb_rd == w_rs1))    ? wb_data : r_regs[w_rs1];
  assign w_rs2_data = (w_rs2 == 5'd0)                  ? 32'd0   :
                      (w_wb_en && (wb_rd == w_rs2))    ? wb_data : r_regs[w_rs2];

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic        w_legal;
  logic        w_alu_src;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_reg_write;
  logic        w_mem_to_reg;
  logic        w_is_jal;
  logic        w_is_beq;
  logic        w_is_bne;
  logic [31:0] w_imm;

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned (which would infer a latch).
  always_comb begin
    w_legal      = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_is_jal     = 1'b0;
    w_is_beq     = 1'b0;
    w_is_bne     = 1'b0;
    w_imm        = 32'd0;
    case (w_opcode)
      OP_R: begin
        w_legal     = 1'b1;
        w_reg_write = 1'b1;
      end
      OP_I: begin
        w_legal     = 1'b1;
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm       = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
      end
      OP_LW: begin
        w_legal      = 1'b1;
        w_reg_write  = 1'b1;
        w_alu_src    = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_imm        = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
      end
      OP_SW: begin
        w_legal     = 1'b1;
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
        w_imm       = {{20{if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
      end
      OP_BR: begin
        w_imm = {{19{if_id_instr[31]}}, if_id_instr[31], if_id_instr[7],
                 if_id_instr[30:25], if_id_instr[11:8], 1'b0};
        // Only BEQ/BNE are implemented; other branch funct3 values are illegal.
        if (w_funct3 == 3'b000) begin
          w_legal  = 1'b1;
          w_is_beq = 1'b1;
        end else if (w_funct3 == 3'b001) begin
          w_legal  = 1'b1;
          w_is_bne = 1'b1;
        end
      end
      OP_JAL: begin
        w_legal     = 1'b1;
        w_reg_write = 1'b1;
        w_is_jal    = 1'b1;
        w_imm       = {{11{if_id_instr[31]}}, if_id_instr[31], if_id_instr[19:12],
                       if_id_instr[20], if_id_instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Branch resolution and squash
  // ---------------------------------------------------------------------------
  logic r_squash;
  logic w_eq;
  logic w_bubble;

  assign w_eq     = (w_rs1_data == w_rs2_data);
  // The instruction right behind a taken branch is wrong-path: it must neither
  // redirect fetch nor reach EX nor raise illegal_instr.
  assign w_bubble = r_squash || !w_legal;

  assign branch_taken  = !rst && !r_squash &&
                         (w_is_jal || (w_is_beq && w_eq) || (w_is_bne && !w_eq));
  assign branch_target = (if_id_pc_plus4 - 32'd4) + w_imm;

  always_ff @(posedge clk) begin
    if (rst) r_squash <= 1'b0;
    else     r_squash <= branch_taken;
  end

  // ---------------------------------------------------------------------------
  // ID/EX register: loads every cycle; bubbles load all zeros.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      id_ex_pc_plus4   <= '0;
      id_ex_rs1_data   <= '0;
      id_ex_rs2_data   <= '0;
      id_ex_imm        <= '0;
      id_ex_rd         <= '0;
      id_ex_funct3     <= '0;
      id_ex_funct7b5   <= 1'b0;
      id_ex_alu_src    <= 1'b0;
      id_ex_mem_read   <= 1'b0;
      id_ex_mem_write  <= 1'b0;
      id_ex_reg_write  <= 1'b0;
      id_ex_mem_to_reg <= 1'b0;
      id_ex_is_jal     <= 1'b0;
    end else begin
      id_ex_pc_plus4   <= if_id_pc_plus4;
      id_ex_rs1_data   <= w_rs1_data;
      id_ex_rs2_data   <= w_rs2_data;
      id_ex_imm        <= w_imm;
      id_ex_rd         <= w_rd;
      id_ex_funct3     <= w_funct3;
      id_ex_funct7b5   <= if_id_instr[30];
      id_ex_alu_src    <= w_alu_src;
      id_ex_mem_read   <= w_mem_read;
      id_ex_mem_write  <= w_mem_write;
      // Writes to x0 are dropped here so later stages need not check rd.
      id_ex_reg_write  <= w_reg_write && (w_rd != 5'd0);
      id_ex_mem_to_reg <= w_mem_to_reg;
      id_ex_is_jal     <= w_is_jal;
    end
  end

  // An all-zero word is treated as an empty slot, not an illegal instruction.
  always_ff @(posedge clk) begin
    if (rst) illegal_instr <= 1'b0;
    else     illegal_instr <= !r_squash && !w_legal && (if_id_instr != 32'h0000_0000);
  end

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage -- self-checking bench for id_stage.
// Directed table of single-cycle vectors (applied in order, state carries),
// a hand-written reset/squash sequence, then randomized instructions checked
// against a behavioural model that tracks the register file and squash slot.
// -----------------------------------------------------------------------------
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] id_ex_pc_plus4, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0]  id_ex_rd;
  logic [2:0]  id_ex_funct3;
  logic        id_ex_funct7b5;
  logic        id_ex_alu_src, id_ex_mem_read, id_ex_mem_write;
  logic        id_ex_reg_write, id_ex_mem_to_reg, id_ex_is_jal;
  logic        illegal_instr;

  always #5 clk = ~clk;

  id_stage dut (
    .clk              (clk),
    .rst              (rst),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_instr      (if_id_instr),
    .wb_reg_write     (wb_reg_write),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .id_ex_pc_plus4   (id_ex_pc_plus4),
    .id_ex_rs1_data   (id_ex_rs1_data),
    .id_ex_rs2_data   (id_ex_rs2_data),
    .id_ex_imm        (id_ex_imm),
    .id_ex_rd         (id_ex_rd),
    .id_ex_funct3     (id_ex_funct3),
    .id_ex_funct7b5   (id_ex_funct7b5),
    .id_ex_alu_src    (id_ex_alu_src),
    .id_ex_mem_read   (id_ex_mem_read),
    .id_ex_mem_write  (id_ex_mem_write),
    .id_ex_reg_write  (id_ex_reg_write),
    .id_ex_mem_to_reg (id_ex_mem_to_reg),
    .id_ex_is_jal     (id_ex_is_jal),
    .illegal_instr    (illegal_instr)
  );

  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;

  typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_JAL, K_BAD, K_ZERO} kind_e;

  // ctl packing: {alu_src, mem_read, mem_write, reg_write, mem_to_reg, is_jal}
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic        taken;
    logic [31:0] target;
    logic [31:0] pc_o;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [5:0]  ctl;
    logic        ill;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- instruction encoders (assemble from a chosen immediate) -------------
  function automatic logic [31:0] enc_r(input logic f7b5, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic we, input logic [4:0] wrd, input logic [31:0] wdata,
                              input logic taken, input logic [31:0] target,
                              input logic [31:0] pc_o, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [31:0] imm,
                              input logic [4:0] rd, input logic [5:0] ctl, input logic ill);
    vec_t v;
    v.pc = pc; v.instr = instr; v.we = we; v.wrd = wrd; v.wdata = wdata;
    v.taken = taken; v.target = target; v.pc_o = pc_o; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.rd = rd; v.ctl = ctl; v.ill = ill;
    return v;
  endfunction

  task automatic drive(input logic a_rst, input logic [31:0] pc, input logic [31:0] instr,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    rst            = a_rst;
    if_id_pc_plus4 = pc;
    if_id_instr    = instr;
    wb_reg_write   = we;
    wb_rd          = wrd;
    wb_data        = wd;
  endtask

  task automatic check_idex(input string tag, input logic [31:0] pc, input logic [31:0] rs1,
                            input logic [31:0] rs2, input logic [31:0] imm,
                            input logic [4:0] rd, input logic [5:0] ctl, input logic ill);
    check({tag, ".pc_plus4"}, id_ex_pc_plus4, pc);
    check({tag, ".rs1_data"}, id_ex_rs1_data, rs1);
    check({tag, ".rs2_data"}, id_ex_rs2_data, rs2);
    check({tag, ".imm"},      id_ex_imm, imm);
    check({tag, ".rd"},       {27'd0, id_ex_rd}, {27'd0, rd});
    check({tag, ".ctl"},      {26'd0, id_ex_alu_src, id_ex_mem_read, id_ex_mem_write,
                               id_ex_reg_write, id_ex_mem_to_reg, id_ex_is_jal}, {26'd0, ctl});
    check({tag, ".illegal"},  {31'd0, illegal_instr}, {31'd0, ill});
  endtask

  // ---- behavioural model state ----------------------------------------------
  logic [31:0] m_regs [32];
  logic        m_sq;

  function automatic logic [31:0] m_read(input logic [4:0] idx, input logic we,
                                         input logic [4:0] wrd, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (we && wrd == idx) return wd;
    return m_regs[idx];
  endfunction

  function automatic logic [5:0] m_ctl(input kind_e k);
    case (k)
      K_R:     return 6'b000100;
      K_I:     return 6'b100100;
      K_LW:    return 6'b110110;
      K_SW:    return 6'b101000;
      K_JAL:   return 6'b000101;
      default: return 6'b000000;
    endcase
  endfunction

  vec_t tbl [19];

  initial begin
    drive(1'b1, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Directed vectors; rows run back-to-back and rely on earlier writebacks.
    tbl[0]  = mk(32'h0, 32'h0, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0);
    tbl[1]  = mk(32'h10, enc_r(0, 5, 5, 0, 6), 0, 0, 0, 0, 0,
                 32'h10, 32'h1234, 32'h1234, 0, 6, 6'b000100, 0);
    tbl[2]  = mk(32'h14, enc_i(0, 0, 0, 0, OP_I), 1, 0, 32'hFFFF_FFFF, 0, 0,
                 32'h14, 0, 0, 0, 0, 6'b100000, 0);
    tbl[3]  = mk(32'h18, enc_r(0, 0, 0, 0, 1), 0, 0, 0, 0, 0,
                 32'h18, 0, 0, 0, 1, 6'b000100, 0);
    tbl[4]  = mk(32'h1C, enc_i(32'hFFFF_FFFF, 7, 0, 8, OP_I), 1, 7, 32'hABCD, 0, 0,
                 32'h1C, 32'hABCD, 0, 32'hFFFF_FFFF, 8, 6'b100100, 0);
    tbl[5]  = mk(32'h20, enc_s(32'hFFFF_FFFC, 7, 1), 1, 1, 32'h55, 0, 0,
                 32'h20, 32'h55, 32'hABCD, 32'hFFFF_FFFC, 28, 6'b101000, 0);
    tbl[6]  = mk(32'h24, enc_i(32'h7FF, 1, 2, 9, OP_LW), 0, 0, 0, 0, 0,
                 32'h24, 32'h55, 0, 32'h7FF, 9, 6'b110110, 0);
    tbl[7]  = mk(32'h104, enc_b(8, 1, 1, 0), 0, 0, 0, 1, 32'h108,
                 32'h104, 32'h55, 32'h55, 8, 8, 6'b000000, 0);
    tbl[8]  = mk(32'h108, enc_i(1, 0, 0, 2, OP_I), 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 0, 6'b000000, 0);
    tbl[9]  = mk(32'h200, enc_b(8, 1, 1, 1), 0, 0, 0, 0, 0,
                 32'h200, 32'h55, 32'h55, 8, 8, 6'b000000, 0);
    tbl[10] = mk(32'h20, enc_j(16, 1), 0, 0, 0, 1, 32'h2C,
                 32'h20, 0, 0, 16, 1, 6'b000101, 0);
    tbl[11] = mk(32'h24, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0);
    tbl[12] = mk(32'h28, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1);
    tbl[13] = mk(32'h2C, enc_b(8, 1, 1, 2), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1);
    tbl[14] = mk(32'h40, enc_j(32'hFFFF_FFFC, 0), 0, 0, 0, 1, 32'h38,
                 32'h40, 0, 0, 32'hFFFF_FFFC, 0, 6'b000001, 0);
    tbl[15] = mk(32'h38, enc_i(3, 0, 0, 4, OP_I), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0);
    tbl[16] = mk(32'h1000, enc_b(32'hFFFF_FFF8, 0, 1, 1), 0, 0, 0, 1, 32'hFF4,
                 32'h1000, 32'h55, 0, 32'hFFFF_FFF8, 25, 6'b000000, 0);
    tbl[17] = mk(32'hFF8, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0);
    tbl[18] = mk(32'h50, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0);

    // ---- reset state --------------------------------------------------------
    repeat (2) @(posedge clk);
    #1;
    check("reset.branch_taken", {31'd0, branch_taken}, 32'd0);
    check_idex("reset", 0, 0, 0, 0, 0, 6'b000000, 0);

    // ---- directed table -----------------------------------------------------
    for (int i = 0; i < 19; i++) begin
      drive(1'b0, tbl[i].pc, tbl[i].instr, tbl[i].we, tbl[i].wrd, tbl[i].wdata);
      @(negedge clk);
      check($sformatf("tbl%0d.taken", i), {31'd0, branch_taken}, {31'd0, tbl[i].taken});
      if (tbl[i].taken) check($sformatf("tbl%0d.target", i), branch_target, tbl[i].target);
      @(posedge clk);
      #1;
      check_idex($sformatf("tbl%0d", i), tbl[i].pc_o, tbl[i].rs1, tbl[i].rs2, tbl[i].imm,
                 tbl[i].rd, tbl[i].ctl, tbl[i].ill);
    end

    // ---- reset right after a taken branch -----------------------------------
    drive(1'b0, 32'h104, enc_b(8, 1, 1, 0), 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("rstseq.branch_taken", {31'd0, branch_taken}, 32'd1);
    @(posedge clk);
    #1;
    // Reset cycle: a writeback to x10 here must be ignored.
    drive(1'b1, 32'h108, enc_j(16, 1), 1'b1, 5'd10, 32'h99);
    @(posedge clk);
    #1;
    check_idex("rstseq.in_rst", 0, 0, 0, 0, 0, 6'b000000, 0);
    // Still in reset, squash now clear: a JAL must not redirect.
    @(negedge clk);
    check("rstseq.taken_in_rst", {31'd0, branch_taken}, 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 32'h60, enc_i(5, 0, 0, 3, OP_I), 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    #1;
    check_idex("rstseq.first", 32'h60, 0, 0, 5, 3, 6'b100100, 0);
    // Register file cleared by reset, and the reset-cycle writeback dropped.
    drive(1'b0, 32'h64, enc_r(0, 10, 1, 0, 4), 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    #1;
    check_idex("rstseq.cleared", 32'h64, 0, 0, 0, 4, 6'b000100, 0);

    // ---- randomized run against the model -----------------------------------
    drive(1'b1, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_sq = 1'b0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        r, we, taken, live;
      logic [4:0]  wrd, rs1, rs2, rd;
      logic [31:0] wd, pc, imm, instr, t, v1, v2;
      kind_e       k;

      r   = ($urandom_range(0, 39) == 0);
      we  = 1'($urandom_range(0, 1));
      wrd = 5'($urandom_range(0, 7));
      wd  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      pc  = $urandom & 32'hFFFF_FFFC;
      k   = kind_e'($urandom_range(0, 8));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = ($urandom_range(0, 1) == 1) ? rs1 : 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      t   = $urandom;
      imm = 32'd0;
      case (k)
        K_R:  instr = enc_r(t[30], rs2, rs1, t[14:12], rd);
        K_I:  begin imm = {{20{t[11]}}, t[11:0]}; instr = enc_i(imm, rs1, t[14:12], rd, OP_I); end
        K_LW: begin imm = {{20{t[11]}}, t[11:0]}; instr = enc_i(imm, rs1, 3'b010, rd, OP_LW); end
        K_SW: begin imm = {{20{t[11]}}, t[11:0]}; instr = enc_s(imm, rs2, rs1); end
        K_BEQ: begin imm = {{19{t[12]}}, t[12:1], 1'b0}; instr = enc_b(imm, rs2, rs1, 3'b000); end
        K_BNE: begin imm = {{19{t[12]}}, t[12:1], 1'b0}; instr = enc_b(imm, rs2, rs1, 3'b001); end
        K_JAL: begin imm = {{11{t[20]}}, t[20:1], 1'b0}; instr = enc_j(imm, rd); end
        K_BAD: begin
          if (t[0]) begin
            instr = $urandom;
            instr[6:0] = 7'b1100011;
            instr[14:12] = 3'($urandom_range(2, 7));
          end else begin
            do instr = $urandom;
            while (instr[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F});
            instr[31] = 1'b1;
          end
        end
        default: instr = 32'd0;
      endcase

      v1    = m_read(instr[19:15], we, wrd, wd);
      v2    = m_read(instr[24:20], we, wrd, wd);
      live  = !r && !m_sq && !(k inside {K_BAD, K_ZERO});
      taken = !r && !m_sq && ((k == K_JAL) || (k == K_BEQ && v1 == v2) ||
                              (k == K_BNE && v1 != v2));

      drive(r, pc, instr, we, wrd, wd);
      @(negedge clk);
      check($sformatf("rnd%0d.taken", cyc), {31'd0, branch_taken}, {31'd0, taken});
      if (taken) check($sformatf("rnd%0d.target", cyc), branch_target, pc - 32'd4 + imm);
      @(posedge clk);
      #1;
      if (live) begin
        logic [5:0] c;
        c = m_ctl(k);
        if (instr[11:7] == 5'd0) c[2] = 1'b0;
        check_idex($sformatf("rnd%0d", cyc), pc, v1, v2, imm, instr[11:7], c, 1'b0);
        check($sformatf("rnd%0d.funct3", cyc), {29'd0, id_ex_funct3}, {29'd0, instr[14:12]});
        check($sformatf("rnd%0d.funct7b5", cyc), {31'd0, id_ex_funct7b5}, {31'd0, instr[30]});
      end else begin
        check_idex($sformatf("rnd%0d", cyc), 0, 0, 0, 0, 0, 6'b000000,
                   !r && !m_sq && (k == K_BAD));
      end

      if (r) begin
        for (int j = 0; j < 32; j++) m_regs[j] = 32'd0;
        m_sq = 1'b0;
      end else begin
        if (we && wrd != 5'd0) m_regs[wrd] = wd;
        m_sq = taken;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
